// File: rtl/banked_instruction_buffer_pkg.sv
// Shared types and sizing helpers for the double-banked PAT instruction buffer.
// DEPTH/WORDS describe the default geometry; parametrised instances size
// themselves through words_of().
package pat_ibuf_pkg;
  typedef enum logic [1:0] {EMPTY, LOADING, FULL} ibuf_state_t;

  localparam int DEF_I_ADR_WIDTH = 10;
  localparam int DEF_I_PER_WORD  = 2;
  localparam int DEPTH = 2 ** DEF_I_ADR_WIDTH;
  localparam int WORDS = DEPTH / DEF_I_PER_WORD;

  // Number of packed load words that fill one bank.
  function automatic int words_of(input int adr_w, input int per_word);
    return (2 ** adr_w) / per_word;
  endfunction
endpackage

// File: rtl/banked_instruction_buffer_ibuf_bank.sv
// ibuf_bank: one instruction bank.
//   clk, reset : clock / async active-high reset (read register only)
//   we, waddr  : write strobe and packed-word index
//   wdata      : I_PER_WORD instructions, instruction k in slice k
//   re, raddr  : read enable and instruction address
//   rdata      : registered instruction (1-cycle latency)
// Memory contents are never reset.
module ibuf_bank #(
  parameter int I_WIDTH     = 20,
  parameter int I_PER_WORD  = 2,
  parameter int I_ADR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [I_ADR_WIDTH-1:0]        waddr,
  input  logic [I_PER_WORD*I_WIDTH-1:0] wdata,
  input  logic                          re,
  input  logic [I_ADR_WIDTH-1:0]        raddr,
  output logic [I_WIDTH-1:0]            rdata
);
  localparam int BANK_DEPTH = 2 ** I_ADR_WIDTH;

  logic [I_WIDTH-1:0] mem [BANK_DEPTH];

  // Word n lands at instruction addresses n*I_PER_WORD + k.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < I_PER_WORD; k++)
        mem[I_ADR_WIDTH'(int'(waddr) * I_PER_WORD + k)] <= wdata[k*I_WIDTH +: I_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/banked_instruction_buffer.sv
// banked_instruction_buffer: two instruction banks; the core reads the active
// bank by pc while a loader fills the shadow bank via valid/ready. A swap
// (swap_req while the shadow is FULL) exchanges the banks atomically.
//   clk, reset            : clock / async active-high reset
//   pc, instruction       : read address, registered instruction (1 cycle)
//   instr_valid           : instruction holds a real program word
//   load_valid/ready/data : packed-word load handshake into the shadow bank
//   load_last             : final word of a program
//   swap_req, swap_ack    : level swap request, one-cycle acknowledge
//   active_bank           : bank currently read by pc
//   shadow_full           : shadow bank holds a complete program
//   load_count            : words accepted into the shadow bank
module banked_instruction_buffer
  import pat_ibuf_pkg::*;
#(
  parameter int I_WIDTH     = 20,
  parameter int I_PER_WORD  = 2,
  parameter int I_ADR_WIDTH = 10,
  parameter int CNT_WIDTH   = I_ADR_WIDTH + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [I_ADR_WIDTH-1:0]        pc,
  output logic [I_WIDTH-1:0]            instruction,
  output logic                          instr_valid,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [I_PER_WORD*I_WIDTH-1:0] load_data,
  input  logic                          load_last,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic                          active_bank,
  output logic                          shadow_full,
  output logic [CNT_WIDTH-1:0]          load_count
);
  localparam int NWORDS = words_of(I_ADR_WIDTH, I_PER_WORD);

  ibuf_state_t state, state_nxt;
  logic accept, swap, at_limit, done;
  logic live;    // a program has been swapped in since reset
  logic rd_sel;  // bank the read register sampled at the last edge
  logic [1:0]              we;
  logic [1:0][I_WIDTH-1:0] rdata;

  assign accept   = load_valid && load_ready;
  assign at_limit = (load_count == CNT_WIDTH'(NWORDS - 1));
  // Filling the last slot is an implicit end of program, so the count
  // saturates at NWORDS instead of wrapping.
  assign done     = accept && (load_last || at_limit);
  // Swap only from FULL: a last word accepted with swap_req high reaches
  // FULL on one edge and swaps on the next.
  assign swap     = swap_req && (state == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = done ? FULL : LOADING;
      LOADING: if (done)   state_nxt = FULL;
      FULL:    if (swap)   state_nxt = EMPTY;
      default:             state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    load_ready  = (state != FULL);
    shadow_full = (state == FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_count  <= '0;
      active_bank <= 1'b0;
      swap_ack    <= 1'b0;
      instr_valid <= 1'b0;
      live        <= 1'b0;
      rd_sel      <= 1'b0;
    end else begin
      if (swap)        load_count <= '0;
      else if (accept) load_count <= load_count + 1'b1;
      if (swap) active_bank <= ~active_bank;
      swap_ack <= swap;
      // Low through the swap_ack cycle, high once the new bank is read.
      if (swap)          instr_valid <= 1'b0;
      else if (swap_ack) instr_valid <= 1'b1;
      if (swap) live <= 1'b1;
      rd_sel <= active_bank;
    end
  end

  // Until the first program is swapped in, the read registers hold their
  // reset value so instruction stays 0 instead of showing uninitialised RAM.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign we[b] = accept && (active_bank != 1'(b));
    ibuf_bank #(
      .I_WIDTH    (I_WIDTH),
      .I_PER_WORD (I_PER_WORD),
      .I_ADR_WIDTH(I_ADR_WIDTH)
    ) u_bank (
      .clk  (clk),
      .reset(reset),
      .we   (we[b]),
      .waddr(I_ADR_WIDTH'(load_count)),
      .wdata(load_data),
      .re   (live),
      .raddr(pc),
      .rdata(rdata[b])
    );
  end

  assign instruction = rd_sel ? rdata[1] : rdata[0];
endmodule

// File: tb/tb_banked_instruction_buffer.sv
module tb_banked_instruction_buffer;
  localparam int IW = 20, IPW = 2, AW = 10, SAW = 3;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]     pc = '0;
  logic [IW-1:0]     instruction;
  logic              instr_valid, load_ready, swap_ack, active_bank, shadow_full;
  logic              load_valid = 1'b0, load_last = 1'b0, swap_req = 1'b0;
  logic [IPW*IW-1:0] load_data = '0;
  logic [AW:0]       load_count;

  logic [SAW-1:0]    s_pc = '0;
  logic [IW-1:0]     s_instruction;
  logic              s_instr_valid, s_load_ready, s_swap_ack, s_active_bank, s_shadow_full;
  logic              s_load_valid = 1'b0, s_load_last = 1'b0, s_swap_req = 1'b0;
  logic [IPW*IW-1:0] s_load_data = '0;
  logic [SAW:0]      s_load_count;

  banked_instruction_buffer #(.I_WIDTH(IW), .I_PER_WORD(IPW), .I_ADR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction), .instr_valid(instr_valid),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .swap_req(swap_req), .swap_ack(swap_ack), .active_bank(active_bank),
    .shadow_full(shadow_full), .load_count(load_count));

  banked_instruction_buffer #(.I_WIDTH(IW), .I_PER_WORD(IPW), .I_ADR_WIDTH(SAW)) dut_s (
    .clk(clk), .reset(reset), .pc(s_pc), .instruction(s_instruction), .instr_valid(s_instr_valid),
    .load_valid(s_load_valid), .load_ready(s_load_ready), .load_data(s_load_data),
    .load_last(s_load_last), .swap_req(s_swap_req), .swap_ack(s_swap_ack),
    .active_bank(s_active_bank), .shadow_full(s_shadow_full), .load_count(s_load_count));

  int checks = 0, errors = 0;
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] mdl [2][2**AW];
  int act_m = 0, cnt_m = 0;
  bit live_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and retire one scoreboard read.
  task automatic tick();
    @(negedge clk);
    if (exp_q.size() != 0) chk("rd_data", 32'(instruction), 32'(exp_q.pop_front()));
  endtask

  task automatic drive_pc(input int p);
    pc = AW'(p);
    if (live_m) exp_q.push_back(mdl[act_m][p]);
  endtask

  task automatic load_word(input logic [IW-1:0] hi, input logic [IW-1:0] lo, input logic last);
    load_valid = 1'b1;
    load_data  = {hi, lo};
    load_last  = last;
    mdl[1-act_m][cnt_m*2]     = lo;
    mdl[1-act_m][cnt_m*2 + 1] = hi;
    cnt_m++;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_bank",  32'(active_bank), 0);
    chk("rst_ack",   32'(swap_ack), 0);
    chk("rst_full",  32'(shadow_full), 0);
    chk("rst_cnt",   32'(load_count), 0);
    chk("rst_ready", 32'(load_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    // No program loaded: outputs stay idle across a pc sweep.
    for (int p = 0; p < 8; p++) begin
      drive_pc(p);
      tick();
      chk("idle_valid", 32'(instr_valid), 0);
      chk("idle_instr", 32'(instruction), 0);
      chk("idle_bank",  32'(active_bank), 0);
      chk("idle_ready", 32'(load_ready), 1);
    end

    // First program, 4 words, last on word 3, into bank 1.
    for (int n = 0; n < 4; n++) begin
      load_word(IW'(2*n+1), IW'(2*n), n == 3);
      tick();
      chk("p1_cnt",   32'(load_count), 32'(cnt_m));
      chk("p1_full",  32'(shadow_full), 32'(n == 3));
      chk("p1_ready", 32'(load_ready), 32'(n != 3));
    end
    load_valid = 1'b0; load_last = 1'b0;
    swap_req = 1'b1;
    tick();
    chk("p1_ack",     32'(swap_ack), 1);
    chk("p1_bank",    32'(active_bank), 1);
    chk("p1_bubble",  32'(instr_valid), 0);
    chk("p1_cnt_clr", 32'(load_count), 0);
    chk("p1_full_clr",32'(shadow_full), 0);
    swap_req = 1'b0; act_m = 1; live_m = 1'b1; cnt_m = 0;
    for (int p = 0; p < 8; p++) begin
      drive_pc(p);
      tick();
      chk("p1_valid", 32'(instr_valid), 1);
      chk("p1_ack_0", 32'(swap_ack), 0);
    end

    // Early swap request held through loading bank 0 while bank 1 is read.
    swap_req = 1'b1;
    drive_pc(0);
    tick();
    chk("p2_noswap", 32'(active_bank), 1);
    for (int n = 0; n < 3; n++) begin
      load_word(IW'(32'h101 + 2*n), IW'(32'h100 + 2*n), n == 2);
      drive_pc(n + 1);
      tick();
      chk("p2_cnt",  32'(load_count), 32'(cnt_m));
      chk("p2_full", 32'(shadow_full), 32'(n == 2));
      chk("p2_ack",  32'(swap_ack), 0);
      chk("p2_bank", 32'(active_bank), 1);
    end
    load_valid = 1'b0; load_last = 1'b0;
    drive_pc(4);
    tick();
    chk("p2_ack",    32'(swap_ack), 1);
    chk("p2_bank",   32'(active_bank), 0);
    chk("p2_bubble", 32'(instr_valid), 0);
    chk("p2_cnt",    32'(load_count), 0);
    swap_req = 1'b0; act_m = 0; cnt_m = 0;
    for (int p = 0; p < 6; p++) begin
      drive_pc(p);
      tick();
      chk("p2_ack_0", 32'(swap_ack), 0);
      chk("p2_valid", 32'(instr_valid), 1);
    end

    // Reset in the middle of a load.
    for (int n = 0; n < 2; n++) begin
      load_word(IW'(32'h301 + 2*n), IW'(32'h300 + 2*n), 1'b0);
      tick();
    end
    load_valid = 1'b0;
    chk("mid_cnt", 32'(load_count), 2);
    #2 reset = 1'b1;
    #1;
    exp_q.delete(); live_m = 1'b0; act_m = 0; cnt_m = 0;
    chk("arst_cnt",   32'(load_count), 0);
    chk("arst_bank",  32'(active_bank), 0);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_full",  32'(shadow_full), 0);
    chk("arst_ready", 32'(load_ready), 1);
    chk("arst_instr", 32'(instruction), 0);
    @(negedge clk);
    reset = 1'b0;

    // Small instance: implicit last after DEPTH/I_PER_WORD = 4 words.
    for (int n = 0; n < 4; n++) begin
      s_load_valid = 1'b1;
      s_load_data  = {IW'(32'h201 + 2*n), IW'(32'h200 + 2*n)};
      tick();
      chk("s_cnt",  32'(s_load_count), 32'(n + 1));
      chk("s_full", 32'(s_shadow_full), 32'(n == 3));
    end
    s_load_data = {IW'(32'hBAD), IW'(32'hBAD)};
    tick();
    chk("s_sat_cnt",   32'(s_load_count), 4);
    chk("s_sat_full",  32'(s_shadow_full), 1);
    chk("s_sat_ready", 32'(s_load_ready), 0);
    s_load_valid = 1'b0;
    s_swap_req = 1'b1;
    tick();
    chk("s_ack",  32'(s_swap_ack), 1);
    chk("s_bank", 32'(s_active_bank), 1);
    s_swap_req = 1'b0;
    for (int p = 0; p < 8; p++) begin
      s_pc = SAW'(p);
      tick();
      chk("s_rd",    32'(s_instruction), 32'h200 + 32'(p));
      chk("s_valid", 32'(s_instr_valid), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/banked_instruction_buffer.md
Name: banked_instruction_buffer

Overview:
Double-banked instruction store for the PAT processor. One bank feeds instructions to the core by pc while a loader fills the other (shadow) bank through a valid/ready handshake, using packed multi-instruction words. A swap request atomically exchanges the banks, so a new pattern program can be loaded without halting the core. Generalises the single-bank buffer: packing factor and depth are parametrised, and it adds the handshake, bank swap and a valid flag.

Parameters:
I_WIDTH, 20, instruction width in bits
I_PER_WORD, 2, instructions packed per load word (power of 2, >=1)
I_ADR_WIDTH, 10, pc width; each bank holds DEPTH = 2**I_ADR_WIDTH instructions
CNT_WIDTH, I_ADR_WIDTH+1, width of load_count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
pc  in  I_ADR_WIDTH  instruction address in the active bank
instruction  out  I_WIDTH  registered instruction read from the active bank
instr_valid  out  1  instruction holds a valid program word
load_valid  in  1  loader presents load_data
load_ready  out  1  buffer accepts a word this cycle
load_data  in  I_PER_WORD*I_WIDTH  packed word; instruction k is at bits [(k+1)*I_WIDTH-1 : k*I_WIDTH]
load_last  in  1  qualifies the final word of a program
swap_req  in  1  level request to exchange banks
swap_ack  out  1  one-cycle pulse in the cycle after the swap edge
active_bank  out  1  bank currently read by pc
shadow_full  out  1  shadow bank holds a complete program
load_count  out  CNT_WIDTH  words accepted into the shadow bank

Behaviour:
- Reset (async): active_bank=0, instruction=0, instr_valid=0, swap_ack=0, shadow_full=0, load_count=0, FSM=EMPTY. Memory contents are not reset.
- Word acceptance: a word is accepted at an edge where load_valid && load_ready.
- Word placement: an accepted word goes to shadow bank addresses load_count*I_PER_WORD + k, for k = 0..I_PER_WORD-1. load_count then increments.
- FSM states: EMPTY, LOADING, FULL.
  - EMPTY: moves to LOADING on first acceptance, or directly to FULL if that word has load_last.
  - LOADING: moves to FULL when load_last is accepted, or when load_count reaches DEPTH/I_PER_WORD (implicit last; no wrap).
  - FULL: holds until swap.
- load_ready = (state != FULL). shadow_full = (state == FULL).
- Swap: occurs at an edge where swap_req && state==FULL.
  - active_bank toggles, state returns to EMPTY, load_count returns to 0.
  - swap_ack is 1 for the following cycle only.
- Early swap request: swap_req asserted while not FULL is held pending by level; the swap happens at the first edge where FULL is true.
- load_last accepted while swap_req is high: FULL is set at edge T and the swap occurs at edge T+1, never in the same edge.
- Read port, 1-cycle latency: at each edge, instruction <= bank[active_bank][pc], using active_bank as it was before the edge.
- instr_valid:
  - 0 from reset until the first swap.
  - At every swap edge instr_valid goes 0; at the next edge it is 1 and instruction comes from the new bank.
  - So instr_valid is low exactly during the swap_ack cycle.
- Loads never write the active bank. Reads and writes of different banks proceed in the same cycle.
- Reset mid-load or mid-swap: partial shadow content is abandoned (count=0, EMPTY) and all outputs take their reset values.
- Arithmetic: address computation is unsigned. load_count saturates at DEPTH/I_PER_WORD and never wraps.

Decomposition:
- Package pat_ibuf_pkg holds: typedef enum {EMPTY, LOADING, FULL} ibuf_state_t; localparam DEPTH; localparam WORDS = DEPTH/I_PER_WORD.
- One sub-module, ibuf_bank: a single bank, I_PER_WORD-wide write / single-instruction synchronous read. Instantiate it twice.
- The top holds the FSM, counter and output muxing.

Test Plan:
- Reset, no load, pc sweeps 0..7 -> instr_valid=0, instruction=0, active_bank=0, load_ready=1.
- Load 4 words (I_PER_WORD=2), word n = {20'h(2n+1), 20'h(2n)}, last on word 3, then swap_req for one cycle -> shadow_full=1 after word 3; swap_ack pulses one cycle later; active_bank=1; pc=0..7 returns 0x0..0x7 one cycle after each pc; instr_valid=1.
- swap_req held high from before the first word, load_last on word 2 -> no swap before FULL; swap at the edge after last acceptance; exactly one swap_ack pulse.
- I_ADR_WIDTH=3, no load_last, 4 words -> FULL after the 4th word, load_ready=0, a 5th load_valid is not accepted, load_count=4.
- Load bank 0 with a second program while pc reads bank 1 -> bank 1 output unchanged throughout; after swap, bank 0 data is returned with one bubble cycle (instr_valid=0).
- Reset asserted after 2 of 4 words -> load_count=0, EMPTY, active_bank=0, instr_valid=0, asynchronously within the reset cycle.
